// File: rtl/shift_reg_sipo_deser.sv
// Serial-in / parallel-out deserializer.
// Collects a qualified serial bit stream into WIDTH-bit words and presents each
// completed word on a valid/ready output. If a word completes while the output
// slot still holds an undelivered word, the new word is dropped and a sticky
// overflow flag is raised.
module shift_reg_sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       overflow,
  output logic [$clog2(WIDTH):0]     fill_level
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // Accumulation stage: partial word and count of bits it holds.
  logic [WIDTH-1:0] sh_p0;
  logic [CW-1:0]    cnt_p0;

  logic             accept;
  logic             complete;
  logic             slot_free;
  logic             drain;
  logic [WIDTH-1:0] shifted;

  // Insert one serial bit into the partial word on the side chosen by MSB_FIRST.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {cur[WIDTH-2:0], b};
    end else begin
      r = {b, cur[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Control decode: clear beats sin_valid; a transfer happens whenever the
  // slot is full and downstream is ready, independent of clear.
  always_comb begin
    accept    = sin_valid && !clear;
    complete  = accept && (cnt_p0 == LAST);
    drain     = dout_valid && dout_ready;
    slot_free = !dout_valid || dout_ready;
    shifted   = shift_in(sh_p0, sin);
  end

  // Bit accumulation: shift in accepted bits, wrap to an empty word on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_p0  <= '0;
      cnt_p0 <= '0;
    end else if (clear) begin
      sh_p0  <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      if (complete) begin
        sh_p0  <= '0;
        cnt_p0 <= '0;
      end else begin
        sh_p0  <= shifted;
        cnt_p0 <= cnt_p0 + CW'(1);
      end
    end
  end

  // Output slot: load a completed word when free, otherwise drop it and flag
  // overflow; a handshake empties the slot unless a new word lands on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        dout       <= shifted;
        dout_valid <= 1'b1;
      end else if (drain) begin
        dout_valid <= 1'b0;
      end
      if (complete && !slot_free) begin
        overflow <= 1'b1;
      end
    end
  end

  // fill_level is the registered bit counter itself, so it never shows WIDTH.
  assign fill_level = cnt_p0;

endmodule

// File: tb/tb_shift_reg_sipo_deser.sv
// Testbench for shift_reg_sipo_deser: directed serial stimulus, expected words
// pushed into per-instance queues, a negedge monitor pops on every handshake.
module tb_shift_reg_sipo_deser;

  logic       clk;
  logic       reset;

  // MSB-first instance
  logic       sin, sin_valid, clear, dout_ready;
  logic [3:0] dout;
  logic       dout_valid, overflow;
  logic [2:0] fill_level;

  // LSB-first instance
  logic       sin_b, sin_valid_b, clear_b, dout_ready_b;
  logic [3:0] dout_b;
  logic       dout_valid_b, overflow_b;
  logic [2:0] fill_level_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] qa[$];
  logic [3:0] qb[$];

  shift_reg_sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overflow(overflow), .fill_level(fill_level)
  );

  shift_reg_sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sin(sin_b), .sin_valid(sin_valid_b), .clear(clear_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .overflow(overflow_b), .fill_level(fill_level_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor A: every handshake must deliver the next expected word.
  always @(negedge clk) begin
    if (reset === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL word_a: got unexpected dout=%b, required no word", dout);
      end else begin
        logic [3:0] e;
        e = qa.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL word_a: got dout=%b, required %b", dout, e);
        end
      end
    end
  end

  // Monitor B: same for the LSB-first instance.
  always @(negedge clk) begin
    if (reset === 1'b0 && dout_valid_b === 1'b1 && dout_ready_b === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL word_b: got unexpected dout=%b, required no word", dout_b);
      end else begin
        logic [3:0] e;
        e = qb.pop_front();
        if (dout_b !== e) begin
          errors++;
          $display("FAIL word_b: got dout=%b, required %b", dout_b, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] bits);  // bits[3] sent first
    for (int i = 3; i >= 0; i--) send(bits[i]);
  endtask

  task automatic send_b(input logic b);
    sin_b       = b;
    sin_valid_b = 1'b1;
    tick();
    sin_valid_b = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sin = 1'b0; sin_valid = 1'b0; clear = 1'b0; dout_ready = 1'b1;
    sin_b = 1'b0; sin_valid_b = 1'b0; clear_b = 1'b0; dout_ready_b = 1'b1;
    repeat (2) tick();
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_fill", fill_level, 0);
    reset = 1'b0;
    tick();

    // 1: basic word, one-cycle valid
    qa.push_back(4'b1011);
    send4(4'b1011);
    chk("t1_valid", dout_valid, 1);
    chk("t1_dout", dout, 4'b1011);
    chk("t1_fill", fill_level, 0);
    chk("t1_ovf", overflow, 0);
    idle(1);
    chk("t1_valid_fall", dout_valid, 0);

    // 2: gaps between bits, fill_level holds
    qa.push_back(4'b0110);
    send(1'b0); chk("t2_fill1", fill_level, 1);
    idle(2);    chk("t2_hold1", fill_level, 1);
    send(1'b1); chk("t2_fill2", fill_level, 2);
    idle(2);    chk("t2_hold2", fill_level, 2);
    send(1'b1); chk("t2_fill3", fill_level, 3);
    idle(2);    chk("t2_hold3", fill_level, 3);
    chk("t2_not_yet", dout_valid, 0);
    send(1'b0);
    chk("t2_valid", dout_valid, 1);
    chk("t2_dout", dout, 4'b0110);
    chk("t2_fill0", fill_level, 0);
    idle(1);

    // 3: backpressure, second word dropped
    dout_ready = 1'b0;
    qa.push_back(4'b1010);
    send4(4'b1010);
    chk("t3_ovf_pre", overflow, 0);
    send4(4'b0101);
    chk("t3_dout_held", dout, 4'b1010);
    chk("t3_valid_held", dout_valid, 1);
    chk("t3_ovf", overflow, 1);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    chk("t3_valid_fall", dout_valid, 0);
    chk("t3_dout_kept", dout, 4'b1010);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: drain and new completion on the same edge
    do_reset();
    chk("t4_reset_ovf", overflow, 0);
    qa.push_back(4'b1100);
    qa.push_back(4'b0111);
    send4(4'b1100);
    send(1'b0); send(1'b1); send(1'b1);
    dout_ready = 1'b1;
    send(1'b1);
    chk("t4_valid", dout_valid, 1);
    chk("t4_dout", dout, 4'b0111);
    chk("t4_ovf", overflow, 0);
    idle(1);
    chk("t4_valid_fall", dout_valid, 0);

    // 5: clear aborts partial word, leaves output slot alone
    dout_ready = 1'b0;
    qa.push_back(4'b1001);
    send4(4'b1001);
    send(1'b1); send(1'b1);
    chk("t5_fill2", fill_level, 2);
    clear = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    clear = 1'b0; sin_valid = 1'b0;
    chk("t5_fill_clr", fill_level, 0);
    chk("t5_valid_kept", dout_valid, 1);
    chk("t5_dout_kept", dout, 4'b1001);
    chk("t5_ovf_kept", overflow, 0);
    dout_ready = 1'b1;
    idle(1);
    qa.push_back(4'b1100);
    send4(4'b1100);
    chk("t5_dout", dout, 4'b1100);
    chk("t5_ovf", overflow, 0);
    idle(1);

    // 6: reset with partial word, pending word and overflow
    dout_ready = 1'b0;
    send4(4'b0011);
    send4(4'b1111);
    send(1'b1); send(1'b0); send(1'b1);
    chk("t6_pre_fill", fill_level, 3);
    chk("t6_pre_valid", dout_valid, 1);
    chk("t6_pre_ovf", overflow, 1);
    chk("t6_pre_dout", dout, 4'b0011);
    do_reset();
    chk("t6_fill", fill_level, 0);
    chk("t6_valid", dout_valid, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_dout", dout, 0);
    dout_ready = 1'b1;

    // 6b: LSB-first ordering
    qb.push_back(4'b0001);
    send_b(1'b1); send_b(1'b0); send_b(1'b0); send_b(1'b0);
    chk("t6b_valid", dout_valid_b, 1);
    chk("t6b_dout", dout_b, 4'b0001);
    idle(1);
    qb.push_back(4'b1011);
    send_b(1'b1); send_b(1'b1); send_b(1'b0); send_b(1'b1);
    chk("t6b_dout2", dout_b, 4'b1011);
    idle(3);

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
